// File: rtl/stream_checker_pkg.sv
// Shared types and constants for the stream_checker AXI4-Stream pattern sink.
// Contents: checker FSM state type, err_flags bit indices, throttle LFSR seed/taps.
// Optional feature macro: STREAM_CHECKER_THROTTLE_EN (LFSR-driven backpressure).
package stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    DRAIN = 2'd2
  } chk_state_t;

  // err_flags bit positions
  localparam int unsigned ERR_DATA  = 0;
  localparam int unsigned ERR_SHORT = 1;
  localparam int unsigned ERR_LONG  = 2;
  localparam int unsigned ERR_SEQ   = 3;
  localparam int unsigned NUM_FLAGS = 4;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form: feedback from bits 15,13,12,10
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/stream_checker_lfsr.sv
// Free-running 16-bit LFSR producing a ~75% duty "ready allowed" strobe.
// Only instantiated when STREAM_CHECKER_THROTTLE_EN is defined.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (loads LFSR_SEED)
//   pass_c out  1 when the low two LFSR bits are not both zero
module stream_checker_lfsr
  import stream_checker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic pass_c
);

  logic [LFSR_W-1:0] lfsr_q;
  logic              fb;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  // Advance every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  assign pass_c = (lfsr_q[1:0] != 2'b00);

endmodule

// File: rtl/stream_checker.sv
// AXI4-Stream byte sink that checks each packet against an incrementing
// pattern (header, then previous byte + 1 mod 256, tlast on byte PKT_LEN-1)
// and keeps packet/error counters and sticky error flags.
// Optional: define STREAM_CHECKER_THROTTLE_EN for pseudo-random backpressure.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous pulse: zero counters/flags, return to IDLE
//   s_axis_t*           8-bit AXI4-Stream slave (tkeep=0 beats are ignored)
//   pkt_count           completed packets (wraps)
//   err_count           packets with any error (saturates)
//   err_flags           sticky {seq gap, long, short, data mismatch}
//   pkt_done / pkt_ok   one-cycle completion pulse and its good/bad status
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int unsigned PKT_LEN = 256,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned ERR_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_FLAGS-1:0] err_flags,
  output logic                 pkt_done,
  output logic                 pkt_ok
);

  localparam int unsigned IDX_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  chk_state_t           state_q, state_d;
  logic [7:0]           expect_q, expect_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           last_hdr_q, last_hdr_d;
  logic                 seq_valid_q, seq_valid_d;
  logic                 pkt_err_q, pkt_err_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 pkt_ok_q, pkt_ok_d;
  logic                 ready_q;
  logic                 beat;
  logic                 complete;
  logic                 err_beat;
  logic                 err_pkt;

  // Ready may only rise once reset has been released
`ifdef STREAM_CHECKER_THROTTLE_EN
  logic lfsr_pass;

  stream_checker_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .pass_c (lfsr_pass)
  );

  assign s_axis_tready = ready_q & lfsr_pass;
`else
  assign s_axis_tready = ready_q;
`endif

  // Null (tkeep=0) beats are consumed but never checked
  assign beat = s_axis_tvalid & s_axis_tready & s_axis_tkeep;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      expect_q    <= '0;
      idx_q       <= '0;
      last_hdr_q  <= '0;
      seq_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      flags_q     <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      idx_q       <= idx_d;
      last_hdr_q  <= last_hdr_d;
      seq_valid_q <= seq_valid_d;
      pkt_err_q   <= pkt_err_d;
      flags_q     <= flags_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      ready_q     <= 1'b1;
    end
  end

  // Next-state, checking and completion bookkeeping
  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    idx_d       = idx_q;
    last_hdr_d  = last_hdr_q;
    seq_valid_d = seq_valid_q;
    pkt_err_d   = pkt_err_q;
    flags_d     = flags_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = 1'b0;
    complete    = 1'b0;
    err_beat    = 1'b0;
    err_pkt     = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      expect_d    = '0;
      idx_d       = '0;
      last_hdr_d  = '0;
      seq_valid_d = 1'b0;
      pkt_err_d   = 1'b0;
      flags_d     = '0;
      pkt_count_d = '0;
      err_count_d = '0;
    end else if (beat) begin
      unique case (state_q)
        IDLE: begin
          expect_d = s_axis_tdata + 8'd1;
          idx_d    = IDX_W'(1);
          if (seq_valid_q && (s_axis_tdata != (last_hdr_q + 8'd1))) begin
            err_beat         = 1'b1;
            flags_d[ERR_SEQ] = 1'b1;
          end
          last_hdr_d  = s_axis_tdata;
          seq_valid_d = 1'b1;
          if (s_axis_tlast) begin
            err_beat           = 1'b1;
            flags_d[ERR_SHORT] = 1'b1;
            complete           = 1'b1;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          if (s_axis_tdata != expect_q) begin
            err_beat          = 1'b1;
            flags_d[ERR_DATA] = 1'b1;
          end
          // Resync on the received byte so one bad byte is not a cascade
          expect_d = s_axis_tdata + 8'd1;
          idx_d    = idx_q + IDX_W'(1);
          if (s_axis_tlast) begin
            if (idx_q != LAST_IDX) begin
              err_beat           = 1'b1;
              flags_d[ERR_SHORT] = 1'b1;
            end
            complete = 1'b1;
            state_d  = IDLE;
          end else if (idx_q == LAST_IDX) begin
            err_beat          = 1'b1;
            flags_d[ERR_LONG] = 1'b1;
            state_d           = DRAIN;
          end
        end
        DRAIN: begin
          if (s_axis_tlast) begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      err_pkt   = pkt_err_q | err_beat;
      pkt_err_d = err_pkt;
      if (complete) begin
        pkt_done_d  = 1'b1;
        pkt_ok_d    = ~err_pkt;
        pkt_count_d = pkt_count_q + CNT_W'(1);
        if (err_pkt && (err_count_q != {ERR_W{1'b1}})) begin
          err_count_d = err_count_q + ERR_W'(1);
        end
        pkt_err_d = 1'b0;
      end
    end
  end

  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
  assign err_flags = flags_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;

endmodule

// File: tb/tb_stream_checker.sv
// Self-checking bench for stream_checker: table of directed packets with
// hand-derived expectations, clear/reset corner sequences, and randomized
// packets scored against a packet-level reference model.
module tb_stream_checker;

  localparam int unsigned PKT_LEN = 256;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned ERR_W   = 16;

  logic             clk;
  logic             rst;
  logic             clear;
  logic [7:0]       s_axis_tdata;
  logic             s_axis_tkeep;
  logic             s_axis_tlast;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [CNT_W-1:0] pkt_count;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       err_flags;
  logic             pkt_done;
  logic             pkt_ok;

  stream_checker #(.PKT_LEN(PKT_LEN), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .err_flags     (err_flags),
    .pkt_done      (pkt_done),
    .pkt_ok        (pkt_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit bubbles  = 0;

  // Reference model: whole-packet view built from the checking rules
  logic [7:0]  q[$];
  logic [7:0]  m_last_hdr;
  bit          m_seq_valid;
  int unsigned m_pc;
  int unsigned m_ec;
  logic [3:0]  m_flags;
  bit          m_ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_last_hdr  = 8'h00;
    m_seq_valid = 0;
    m_pc        = 0;
    m_ec        = 0;
    m_flags     = 4'h0;
  endtask

  task automatic model_complete();
    logic [3:0] fl;
    int n, lim;
    logic [7:0] nxt;
    fl = 4'h0;
    n  = q.size();
    nxt = m_last_hdr + 8'd1;
    if (m_seq_valid && q[0] != nxt) fl[3] = 1'b1;
    m_last_hdr  = q[0];
    m_seq_valid = 1;
    lim = (n < int'(PKT_LEN)) ? n : int'(PKT_LEN);
    for (int i = 1; i < lim; i++) begin
      nxt = q[i-1] + 8'd1;
      if (q[i] != nxt) fl[0] = 1'b1;
    end
    if (n < int'(PKT_LEN)) fl[1] = 1'b1;
    if (n > int'(PKT_LEN)) fl[2] = 1'b1;
    m_ok    = (fl == 4'h0);
    m_flags = m_flags | fl;
    m_pc++;
    if (!m_ok && m_ec < 65535) m_ec++;
    q.delete();
  endtask

  // Present one beat, wait (bounded) for acceptance, then score it
  task automatic send(input logic [7:0] d, input logic keep, input logic last, input logic clr);
    bit acc;
    int waited;
    if (bubbles && $urandom_range(0, 7) == 0) begin
      @(posedge clk); #1;
    end
    s_axis_tdata  = d;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    clear         = clr;
    acc    = 0;
    waited = 0;
    while (!acc && waited < 200) begin
      acc = s_axis_tready;
      @(posedge clk); #1;
      waited++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = 1'b0;
    s_axis_tlast  = 1'b0;
    clear         = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (clr) begin
      model_reset();
      return;
    end
    if (keep) begin
      q.push_back(d);
      if (last) begin
        model_complete();
        chk("done_pulse", 32'(pkt_done), 32'd1);
        chk("model_ok", 32'(pkt_ok), 32'(m_ok));
        chk("model_pkt_count", pkt_count, m_pc);
        chk("model_err_count", 32'(err_count), m_ec);
        chk("model_flags", 32'(err_flags), 32'(m_flags));
        return;
      end
    end
    chk("no_done_mid", 32'(pkt_done), 32'd0);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len, input int bad_idx,
                          input logic [7:0] bad_val, input bit nulls);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = hdr + 8'(i);
      if (i == bad_idx) b = bad_val;
      if (nulls && i == 10) begin
        send(8'hAA, 1'b0, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b1, 1'b0);
      end
      send(b, 1'b1, (i == len - 1), 1'b0);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         clr;
    logic [7:0] hdr;
    int         len;
    int         bad_idx;
    bit         nulls;
    bit         ok;
    logic [3:0] flags;
    int         pc;
    int         ec;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 8'h05, 256, -1, 0, 1, 4'b0000, 1, 0};
    vecs[1]  = '{0, 8'h06, 256, -1, 0, 1, 4'b0000, 2, 0};
    vecs[2]  = '{1, 8'h10, 256, 20, 0, 0, 4'b0001, 1, 1};
    vecs[3]  = '{0, 8'h11, 100, -1, 0, 0, 4'b0011, 2, 2};
    vecs[4]  = '{0, 8'h12, 300, -1, 0, 0, 4'b0111, 3, 3};
    vecs[5]  = '{1, 8'hFF, 256, -1, 0, 1, 4'b0000, 1, 0};
    vecs[6]  = '{0, 8'h00, 256, -1, 0, 1, 4'b0000, 2, 0};
    vecs[7]  = '{0, 8'h02, 256, -1, 0, 0, 4'b1000, 3, 1};
    vecs[8]  = '{0, 8'h03, 256, -1, 1, 1, 4'b1000, 4, 1};
    vecs[9]  = '{0, 8'h04, 1,   -1, 0, 0, 4'b1010, 5, 2};
    vecs[10] = '{0, 8'h05, 255, -1, 0, 0, 4'b1010, 6, 3};

    rst           = 1'b1;
    clear         = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tkeep  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    model_reset();

    // Reset values
    #1;
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_flags", 32'(err_flags), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("tready_before_edge", 32'(s_axis_tready), 32'd0);
    @(posedge clk); #1;
    chk("tready_after_release", 32'(s_axis_tready), 32'd1);

    // Directed table
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].clr) pulse_clear();
      send_pkt(vecs[v].hdr, vecs[v].len, vecs[v].bad_idx, 8'h00, vecs[v].nulls);
      chk($sformatf("vec%0d_ok", v), 32'(pkt_ok), 32'(vecs[v].ok));
      chk($sformatf("vec%0d_flags", v), 32'(err_flags), 32'(vecs[v].flags));
      chk($sformatf("vec%0d_pkt_count", v), pkt_count, 32'(vecs[v].pc));
      chk($sformatf("vec%0d_err_count", v), 32'(err_count), 32'(vecs[v].ec));
    end

    // One byte over: long packet, single completion at its tlast
    send_pkt(8'h06, 257, -1, 8'h00, 0);
    chk("long257_flags", 32'(err_flags), 32'b1110);
    chk("long257_pkt_count", pkt_count, 32'd7);

    // clear on the same cycle as an accepted beat wins over the beat
    send(8'h20, 1'b1, 1'b0, 1'b0);
    send(8'h21, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b1);
    chk("clear_pkt_count", pkt_count, 32'd0);
    chk("clear_err_count", 32'(err_count), 32'd0);
    chk("clear_flags", 32'(err_flags), 32'd0);
    chk("clear_done", 32'(pkt_done), 32'd0);
    // Back in IDLE with no sequence history: any header starts a clean packet
    send_pkt(8'h40, 256, -1, 8'h00, 0);
    chk("post_clear_ok", 32'(pkt_ok), 32'd1);
    chk("post_clear_pkt_count", pkt_count, 32'd1);

    // Reset mid-packet zeroes outputs without a clock edge
    send_pkt(8'h41, 256, 5, 8'hEE, 0);
    send(8'h42, 1'b1, 1'b0, 1'b0);
    send(8'h43, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_tready", 32'(s_axis_tready), 32'd0);
    chk("midrst_pkt_count", pkt_count, 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_flags", 32'(err_flags), 32'd0);
    chk("midrst_done", 32'(pkt_done), 32'd0);
    chk("midrst_ok", 32'(pkt_ok), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    send_pkt(8'h90, 256, -1, 8'h00, 0);
    chk("post_rst_ok", 32'(pkt_ok), 32'd1);

    // Randomized packets against the model
    bubbles = 1;
    for (int p = 0; p < 14; p++) begin
      logic [7:0] hdr;
      int len, bad, sel;
      hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (m_last_hdr + 8'd1);
      sel = $urandom_range(0, 6);
      case (sel)
        0: len = 1;
        1: len = 2;
        2: len = $urandom_range(3, 254);
        3: len = 255;
        4: len = 256;
        5: len = 257;
        default: len = $urandom_range(258, 300);
      endcase
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 300) : -1;
      send_pkt(hdr, len, bad, 8'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
